// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW + 1R synchronous SRAM model: lane-masked writes on port 0,
// 1- or 2-cycle registered reads on both ports, defined read-during-write and a collision pulse.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  localparam int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
    $fatal(1, "sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic                  rd0_en;
  logic                  rd1_en;
  logic                  rdw_hit;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd0_word;
  logic [DATA_WIDTH-1:0] rd1_word;

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  dout0_vld_q, dout0_vld_d;
  logic                  dout1_vld_q, dout1_vld_d;
  logic                  collision_q, collision_d;

  // wr_word is the full post-write word, so write-first bypass on port 1 is just a mux
  always_comb begin
    wr_en    = !csb0 && !web0;
    rd0_en   = !csb0 && web0;
    rd1_en   = !csb1;
    rdw_hit  = wr_en && rd1_en && (addr0 == addr1);
    rd0_word = mem[addr0];
    wr_word  = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        wr_word[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
    rd1_word = mem[addr1];
    if (RDW_MODE == 1 && rdw_hit) begin
      rd1_word = wr_word;
    end
    collision_d = rdw_hit;
  end

  // The array itself is never cleared; the reset term only blocks writes while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_en) begin
      mem[addr0] <= wr_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  p0_vld_q, p0_vld_d;
    logic                  p1_vld_q, p1_vld_d;
    logic [DATA_WIDTH-1:0] p0_data_q, p0_data_d;
    logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;

    always_comb begin
      p0_vld_d    = rd0_en;
      p0_data_d   = rd0_en ? rd0_word : p0_data_q;
      p1_vld_d    = rd1_en;
      p1_data_d   = rd1_en ? rd1_word : p1_data_q;
      dout0_vld_d = p0_vld_q;
      dout0_d     = p0_vld_q ? p0_data_q : dout0_q;
      dout1_vld_d = p1_vld_q;
      dout1_d     = p1_vld_q ? p1_data_q : dout1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p0_vld_q  <= 1'b0;
        p1_vld_q  <= 1'b0;
        p0_data_q <= '0;
        p1_data_q <= '0;
      end else begin
        p0_vld_q  <= p0_vld_d;
        p1_vld_q  <= p1_vld_d;
        p0_data_q <= p0_data_d;
        p1_data_q <= p1_data_d;
      end
    end
  end else begin : g_lat1
    always_comb begin
      dout0_vld_d = rd0_en;
      dout0_d     = rd0_en ? rd0_word : dout0_q;
      dout1_vld_d = rd1_en;
      dout1_d     = rd1_en ? rd1_word : dout1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0_q     <= '0;
      dout1_q     <= '0;
      dout0_vld_q <= 1'b0;
      dout1_vld_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      dout0_vld_q <= dout0_vld_d;
      dout1_vld_q <= dout1_vld_d;
      collision_q <= collision_d;
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign dout0_vld = dout0_vld_q;
  assign dout1_vld = dout1_vld_q;
  assign collision = collision_q;

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
- Parametrised, synthesisable dual-port (1RW + 1R) SRAM model; successor to the fixed 32x256 macro model used by the TCAM datapath.
- Single clock, configurable data width, depth, byte-mask granularity and read latency.
- Defined read-during-write semantics, deterministic output hold, read-valid strobes and a collision flag replace the X-driving delay model, so the TCAM match/update logic can be verified cycle-accurately.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- WMASK_WIDTH, 8, bits per write-mask lane; DATA_WIDTH must be a multiple of it, else elaboration $fatal.
- NUM_WMASKS, DATA_WIDTH/WMASK_WIDTH, derived; not overridable.
- READ_LATENCY, 1, 1 or 2 cycles from accepted read to dout; any other value causes elaboration $fatal.
- RDW_MODE, 0, port-1 read of the address port 0 is writing in the same cycle: 0 = old data (read-first), 1 = new merged data (write-first bypass).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csb0  in  1  port 0 chip select, active low
- web0  in  1  port 0 write enable, active low
- wmask0  in  NUM_WMASKS  per-lane write enable, active high
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_vld  out  1  dout0 updated this cycle
- csb1  in  1  port 1 chip select, active low
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- dout1_vld  out  1  dout1 updated this cycle
- collision  out  1  registered pulse: same-cycle port-0 write and port-1 read to the same address

Behaviour:
- All activity occurs on posedge clk only. There is no negedge logic and no # delays.
- Reset (rst_n low, asynchronous) clears dout0, dout1, dout0_vld, dout1_vld, collision and all pipeline valid bits to 0. Memory array contents are not reset (X in simulation). Writes and reads are ignored while rst_n is low.
- Write (csb0=0, web0=0): at posedge N, lane i (bits i*WMASK_WIDTH +: WMASK_WIDTH) of mem[addr0] takes din0 where wmask0[i]=1. Other lanes are unchanged. wmask0=0 performs no update. A write does not alter dout0 or dout0_vld.
- Port 0 read (csb0=0, web0=1) accepted at edge N:
  - READ_LATENCY=1: dout0 = mem[addr0] and dout0_vld=1 after edge N+1.
  - READ_LATENCY=2: the data passes through an extra output register; dout0 and dout0_vld update after edge N+2.
- Port 1 read (csb1=0) follows the same rule with dout1/dout1_vld. Port 1 has no write capability.
- Output hold: when no read completes in a cycle, dout keeps its last value and vld=0. A dout is never driven to X.
- Back-to-back reads, one per cycle per port, are fully pipelined; throughput is 1 read per port per cycle.
- Read-during-write on port 1 (port-0 write and port-1 read, same address, same edge):
  - RDW_MODE=0: dout1 returns the pre-write word.
  - RDW_MODE=1: dout1 returns the pre-write word with masked lanes replaced by din0.
- collision = 1 for exactly one cycle, aligned to the edge after the conflicting edge (N+1), regardless of RDW_MODE and wmask0. It is 0 otherwise.
- Port 0 cannot read and write in one cycle, so there is no port-0 self-conflict.
- Address wrap: addr is an unsigned index over the full 2**ADDR_WIDTH range. No out-of-range case exists.
- Reset asserted mid-pipeline discards in-flight reads: no vld is issued for them after rst_n deasserts. Memory writes already committed at earlier edges persist.
- In-pipeline reads are unaffected by later writes: data is captured at the accepting edge.

Test Plan:
- Defaults. Write addr0=0x10, din0=0xDEADBEEF, wmask0=4'b1111. Then port-0 read 0x10 -> dout0=0xDEADBEEF, dout0_vld=1 exactly one cycle after the read edge.
- Partial mask. After test 1, write 0x10 with din0=0x11223344, wmask0=4'b0101. Port-1 read 0x10 -> dout1=0xDE22BE44.
- RDW_MODE=0, then 1. Preload 0x20=0xAAAAAAAA. Same edge: write 0x20=0x55555555 mask 4'b1111 and port-1 read 0x20.
  - RDW_MODE=0 -> dout1=0xAAAAAAAA.
  - RDW_MODE=1 -> dout1=0x55555555.
  - Both modes -> collision=1 for one cycle only.
- READ_LATENCY=2. Read 0x01, 0x02, 0x03 on consecutive cycles on both ports -> data appears 2 cycles later in order, vld high 3 consecutive cycles. dout holds its last value afterwards with vld=0.
- Reset mid-op. Issue a read with READ_LATENCY=2 and pull rst_n low asynchronously before it completes -> dout0=0, dout0_vld=0 immediately and no stale vld after release. Previously written data is still readable.
- Config sweep: DATA_WIDTH=64, WMASK_WIDTH=16, ADDR_WIDTH=4. Write addr 0xF, mask 4'b1000 -> only bits [63:48] change. Read of addr 0x0 is unaffected.
